wait_state_ctrl: RTL and testbench



---
 rtl/gba_mem_pkg.sv | 84 ++++++++
 rtl/ws_region_decode.sv | 83 ++++++++
 rtl/wait_state_ctrl.sv | 147 ++++++++++++++
 tb/tb_wait_state_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gba_mem_pkg.sv
// Shared GBA memory-map types: region enum, region bounds, bus widths and WAITCNT wait tables.
// The access-size codes remain the legacy MEM_SIZE_* defines.
`ifndef MEM_SIZE_BYTE
`define MEM_SIZE_BYTE 2'b00
`endif
`ifndef MEM_SIZE_HALF
`define MEM_SIZE_HALF 2'b01
`endif
`ifndef MEM_SIZE_WORD
`define MEM_SIZE_WORD 2'b10
`endif

package gba_mem_pkg;

   typedef enum logic [3:0] {
      REG_BIOS     = 4'h0,
      REG_UNMAPPED = 4'h1,
      REG_EWRAM    = 4'h2,
      REG_IWRAM    = 4'h3,
      REG_IO       = 4'h4,
      REG_PAL      = 4'h5,
      REG_VRAM     = 4'h6,
      REG_OAM      = 4'h7,
      REG_WS0      = 4'h8,
      REG_WS1      = 4'hA,
      REG_WS2      = 4'hC,
      REG_SRAM     = 4'hE
   } mem_region_t;

   typedef enum logic [1:0] {
      BUS_8  = 2'd0,
      BUS_16 = 2'd1,
      BUS_32 = 2'd2
   } bus_width_t;

   // Region bounds expressed as addr[27:24]
   localparam logic [3:0] BIOS_START    = 4'h0;
   localparam logic [3:0] EWRAM_START   = 4'h2;
   localparam logic [3:0] IWRAM_START   = 4'h3;
   localparam logic [3:0] IO_START      = 4'h4;
   localparam logic [3:0] PAL_START     = 4'h5;
   localparam logic [3:0] VRAM_START    = 4'h6;
   localparam logic [3:0] OAM_START     = 4'h7;
   localparam logic [3:0] ROM_WS0_START = 4'h8;
   localparam logic [3:0] ROM_WS0_END   = 4'h9;
   localparam logic [3:0] ROM_WS1_START = 4'hA;
   localparam logic [3:0] ROM_WS1_END   = 4'hB;
   localparam logic [3:0] ROM_WS2_START = 4'hC;
   localparam logic [3:0] ROM_WS2_END   = 4'hD;
   localparam logic [3:0] SRAM_START    = 4'hE;
   localparam logic [3:0] SRAM_END      = 4'hF;

   localparam logic [3:0] WAIT_N_CODE0 = 4'd4;
   localparam logic [3:0] WAIT_N_CODE1 = 4'd3;
   localparam logic [3:0] WAIT_N_CODE2 = 4'd2;
   localparam logic [3:0] WAIT_N_CODE3 = 4'd8;
   localparam logic [3:0] WS0_S_SLOW   = 4'd2;
   localparam logic [3:0] WS1_S_SLOW   = 4'd4;
   localparam logic [3:0] WS2_S_SLOW   = 4'd8;
   localparam logic [3:0] WS_S_FAST    = 4'd1;
   localparam logic [3:0] EWRAM_WAIT   = 4'd2;

   function automatic logic [3:0] n_wait_lut(input logic [1:0] code);
      logic [3:0] n;
      case (code)
         2'd0:    n = WAIT_N_CODE0;
         2'd1:    n = WAIT_N_CODE1;
         2'd2:    n = WAIT_N_CODE2;
         default: n = WAIT_N_CODE3;
      endcase
      return n;
   endfunction

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      logic [2:0] b;
      case (size)
         `MEM_SIZE_BYTE: b = 3'd1;
         `MEM_SIZE_HALF: b = 3'd2;
         default:        b = 3'd4;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/ws_region_decode.sv
// Combinational GBA region decode: region, bus width, N/S wait counts and illegal-access flag.
module ws_region_decode
   import gba_mem_pkg::*;
(
   input  logic [31:0] addr,
   input  logic        write,
   input  logic [15:0] waitcnt,
   output mem_region_t region,
   output bus_width_t  bus_width,
   output logic [3:0]  n_wait,
   output logic [3:0]  s_wait,
   output logic        illegal
);

   logic unused_bits_s;
   assign unused_bits_s = ^{addr[23:0], waitcnt[15:11]};

   // Map the address nibble to a region; anything above 0x0FFF_FFFF is unmapped
   always_comb begin
      region = REG_UNMAPPED;
      if (addr[31:28] != 4'h0) begin
         region = REG_UNMAPPED;
      end else begin
         case (addr[27:24])
            BIOS_START:                 region = REG_BIOS;
            EWRAM_START:                region = REG_EWRAM;
            IWRAM_START:                region = REG_IWRAM;
            IO_START:                   region = REG_IO;
            PAL_START:                  region = REG_PAL;
            VRAM_START:                 region = REG_VRAM;
            OAM_START:                  region = REG_OAM;
            ROM_WS0_START, ROM_WS0_END: region = REG_WS0;
            ROM_WS1_START, ROM_WS1_END: region = REG_WS1;
            ROM_WS2_START, ROM_WS2_END: region = REG_WS2;
            SRAM_START, SRAM_END:       region = REG_SRAM;
            default:                    region = REG_UNMAPPED;
         endcase
      end
   end

   // Per-region timing and write protection
   always_comb begin
      bus_width = BUS_32;
      n_wait    = 4'd0;
      s_wait    = 4'd0;
      illegal   = 1'b0;
      case (region)
         REG_BIOS: illegal = write;
         REG_IWRAM, REG_IO, REG_OAM: bus_width = BUS_32;
         REG_PAL, REG_VRAM: bus_width = BUS_16;
         REG_EWRAM: begin
            bus_width = BUS_16;
            n_wait    = EWRAM_WAIT;
            s_wait    = EWRAM_WAIT;
         end
         REG_WS0: begin
            bus_width = BUS_16;
            n_wait    = n_wait_lut(waitcnt[3:2]);
            s_wait    = waitcnt[4] ? WS_S_FAST : WS0_S_SLOW;
            illegal   = write;
         end
         REG_WS1: begin
            bus_width = BUS_16;
            n_wait    = n_wait_lut(waitcnt[6:5]);
            s_wait    = waitcnt[7] ? WS_S_FAST : WS1_S_SLOW;
            illegal   = write;
         end
         REG_WS2: begin
            bus_width = BUS_16;
            n_wait    = n_wait_lut(waitcnt[9:8]);
            s_wait    = waitcnt[10] ? WS_S_FAST : WS2_S_SLOW;
            illegal   = write;
         end
         REG_SRAM: begin
            bus_width = BUS_8;
            n_wait    = n_wait_lut(waitcnt[1:0]);
            s_wait    = n_wait_lut(waitcnt[1:0]);
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/wait_state_ctrl.sv
// Turns accepted ARM7 bus accesses into PAUSE wait cycles and one-cycle ABORT flags.
// Define WSC_SEQ_DETECT_EN for sequential (S) timing; otherwise every access is timed as N.
module wait_state_ctrl
   import gba_mem_pkg::*;
#(
   parameter int MAX_WAIT = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   input  logic        write,
   input  logic [15:0] waitcnt,
   output logic        pause,
   output logic        abort,
   output logic        seq
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_STALL = 1'b1} state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             pause_r;
   logic             abort_r;
   logic             seq_r;

   mem_region_t      region_s;
   bus_width_t       bus_width_s;
   logic [3:0]       n_wait_s;
   logic [3:0]       s_wait_s;
   logic             illegal_s;
   logic             is_seq_s;
   logic [3:0]       first_wait_s;
   logic [CNT_W-1:0] wait_s;

   ws_region_decode u_decode (
      .addr      (addr),
      .write     (write),
      .waitcnt   (waitcnt),
      .region    (region_s),
      .bus_width (bus_width_s),
      .n_wait    (n_wait_s),
      .s_wait    (s_wait_s),
      .illegal   (illegal_s)
   );

`ifdef WSC_SEQ_DETECT_EN
   logic        prev_valid_r;
   logic [31:0] prev_next_r;
   mem_region_t prev_region_r;
   logic        rom_region_s;

   // Sequential = continues the last legal access in the same region; ROM 128 KiB pages force N
   always_comb begin
      rom_region_s = (region_s == REG_WS0) || (region_s == REG_WS1) || (region_s == REG_WS2);
      if (rom_region_s && (addr[16:0] == 17'd0)) begin
         is_seq_s = 1'b0;
      end else begin
         is_seq_s = prev_valid_r && (addr == prev_next_r) && (region_s == prev_region_r);
      end
   end

   // Remember the last legal access; a free bus cycle breaks the burst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_valid_r  <= 1'b0;
         prev_next_r   <= 32'h0000_0000;
         prev_region_r <= REG_BIOS;
      end else if (!pause_r) begin
         if (req) begin
            if (!illegal_s) begin
               prev_valid_r  <= 1'b1;
               prev_next_r   <= addr + {29'd0, size_bytes(size)};
               prev_region_r <= region_s;
            end
         end else begin
            prev_valid_r <= 1'b0;
         end
      end
   end
`else
   logic unused_region_s;
   assign unused_region_s = ^{region_s};
   assign is_seq_s        = 1'b0;
`endif

   // Wait count: first beat plus the second-beat penalty for words on a 16-bit bus
   always_comb begin
      first_wait_s = is_seq_s ? s_wait_s : n_wait_s;
      wait_s       = {CNT_W{1'b0}};
      if (illegal_s) begin
         wait_s = {CNT_W{1'b0}};
      end else if ((bus_width_s == BUS_16) && (size == `MEM_SIZE_WORD)) begin
         wait_s = CNT_W'(first_wait_s) + CNT_W'(s_wait_s) + CNT_W'(1'b1);
      end else begin
         wait_s = CNT_W'(first_wait_s);
      end
   end

   // IDLE/STALL controller with registered pause, abort and seq
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         pause_r <= 1'b0;
         abort_r <= 1'b0;
         seq_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req) begin
                  abort_r <= illegal_s;
                  seq_r   <= is_seq_s & ~illegal_s;
                  if (wait_s != {CNT_W{1'b0}}) begin
                     cnt_r   <= wait_s;
                     pause_r <= 1'b1;
                     state_r <= ST_STALL;
                  end
               end else begin
                  abort_r <= 1'b0;
               end
            end
            ST_STALL: begin
               abort_r <= 1'b0;
               cnt_r   <= cnt_r - CNT_W'(1'b1);
               if (cnt_r == CNT_W'(1'b1)) begin
                  pause_r <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               pause_r <= 1'b0;
               abort_r <= 1'b0;
            end
         endcase
      end
   end

   assign pause = pause_r;
   assign abort = abort_r;
   assign seq   = seq_r;

endmodule

// File: tb/tb_wait_state_ctrl.sv
// Self-checking bench for wait_state_ctrl: directed cases plus randomized accesses vs. a region-rule model.
`timescale 1ns/1ps
module tb_wait_state_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [31:0] addr;
   logic [1:0]  size;
   logic        write;
   logic [15:0] waitcnt;
   logic        pause;
   logic        abort;
   logic        seq;

   int n_checks = 0;
   int n_fail   = 0;

   bit          m_prev_valid;
   logic [31:0] m_prev_end;
   int          m_prev_grp;
   int          exp_w;
   bit          exp_abort;
   bit          exp_seq;
   logic [31:0] last_end;

   logic [31:0] r_addr;
   logic [1:0]  r_size;
   logic        r_write;
   logic [15:0] r_wc;
   int          mode;

   localparam logic [1:0] SZ_HALF = `MEM_SIZE_HALF;
   localparam logic [1:0] SZ_WORD = `MEM_SIZE_WORD;

   wait_state_ctrl #(.MAX_WAIT(17)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .addr    (addr),
      .size    (size),
      .write   (write),
      .waitcnt (waitcnt),
      .pause   (pause),
      .abort   (abort),
      .seq     (seq)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, want);
      end
   endtask

   // Region group: -1 unmapped, else the region's first address nibble
   function automatic int grp_of(input logic [31:0] a);
      int r;
      r = int'(a[27:24]);
      if (a[31:28] != 4'h0 || r == 1) return -1;
      if (r >= 8) return r - (r % 2);
      return r;
   endfunction

   function automatic int nbytes(input logic [1:0] s);
      if (s == `MEM_SIZE_BYTE) return 1;
      if (s == `MEM_SIZE_HALF) return 2;
      return 4;
   endfunction

   task automatic model_access(input logic [31:0] a, input logic [1:0] s, input logic wr, input logic [15:0] wc);
      int ntab[4] = '{4, 3, 2, 8};
      int g, n, sw, bus;
      bit ill, sq;
      g = grp_of(a); n = 0; sw = 0; bus = 32;
      case (g)
         2:       begin n = 2; sw = 2; bus = 16; end
         5, 6:    bus = 16;
         8:       begin n = ntab[wc[3:2]]; sw = wc[4]  ? 1 : 2; bus = 16; end
         10:      begin n = ntab[wc[6:5]]; sw = wc[7]  ? 1 : 4; bus = 16; end
         12:      begin n = ntab[wc[9:8]]; sw = wc[10] ? 1 : 8; bus = 16; end
         14:      begin n = ntab[wc[1:0]]; sw = n; bus = 8; end
         default: bus = 32;
      endcase
      ill = (g < 0) || (wr && (g == 0 || g == 8 || g == 10 || g == 12));
      sq = 1'b0;
`ifdef WSC_SEQ_DETECT_EN
      sq = m_prev_valid && (a == m_prev_end) && (g == m_prev_grp) && !(g >= 8 && g <= 12 && a[16:0] == 17'd0);
`endif
      exp_abort = ill;
      if (ill) begin
         exp_w   = 0;
         exp_seq = 1'b0;
      end else begin
         exp_w   = (sq ? sw : n) + ((bus == 16 && s == `MEM_SIZE_WORD) ? sw + 1 : 0);
         exp_seq = sq;
         m_prev_valid = 1'b1;
         m_prev_end   = a + nbytes(s);
         m_prev_grp   = g;
      end
   endtask

   task automatic access(input string tag, input logic [31:0] a, input logic [1:0] s, input logic wr, input logic [15:0] wc);
      int cnt;
      model_access(a, s, wr, wc);
      addr = a; size = s; write = wr; waitcnt = wc; req = 1'b1;
      @(posedge clk); #1;
      check_eq({tag, ".abort"}, {31'd0, abort}, {31'd0, exp_abort});
      check_eq({tag, ".seq"}, {31'd0, seq}, {31'd0, exp_seq});
      cnt = 0;
      while (pause === 1'b1 && cnt < 40) begin
         if (cnt == 0) waitcnt = 16'($urandom);
         @(posedge clk); #1;
         cnt++;
      end
      check_eq({tag, ".wait"}, cnt, exp_w);
      last_end = a + nbytes(s);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         req = 1'b0;
         @(posedge clk); #1;
         m_prev_valid = 1'b0;
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req = 1'b0; addr = 32'd0; size = 2'd0; write = 1'b0; waitcnt = 16'h0000;
      m_prev_valid = 1'b0; m_prev_end = 32'd0; m_prev_grp = -1; last_end = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset.pause", {31'd0, pause}, 32'd0);
      check_eq("reset.abort", {31'd0, abort}, 32'd0);
      check_eq("reset.seq", {31'd0, seq}, 32'd0);
      rst = 1'b0;

      idle(1);
      access("ws0_word_n", 32'h0800_0000, SZ_WORD, 1'b0, 16'h0000);
      access("ws0_word_s", 32'h0800_0004, SZ_WORD, 1'b0, 16'h0000);
      idle(1);
      access("ws0_half_n", 32'h0800_0000, SZ_HALF, 1'b0, 16'h0014);
      access("ws0_half_s", 32'h0800_0002, SZ_HALF, 1'b0, 16'h0014);
      idle(1);
      access("ewram_word", 32'h0200_0000, SZ_WORD, 1'b0, 16'h0000);
      idle(1);
      access("ewram_half", 32'h0200_0000, SZ_HALF, 1'b0, 16'h0000);
      access("iwram_a", 32'h0300_0000, SZ_WORD, 1'b0, 16'h0000);
      access("iwram_b", 32'h0300_0010, SZ_WORD, 1'b0, 16'h0000);
      access("rom_write", 32'h0800_0000, SZ_WORD, 1'b1, 16'h0000);
      idle(1);
      check_eq("rom_write.abort_clear", {31'd0, abort}, 32'd0);
      access("unmapped_rd", 32'h0100_0000, SZ_WORD, 1'b0, 16'h0000);
      idle(1);
      check_eq("unmapped_rd.abort_clear", {31'd0, abort}, 32'd0);
      access("bound_a", 32'h0801_FFFE, SZ_HALF, 1'b0, 16'h0000);
      access("bound_b", 32'h0802_0000, SZ_HALF, 1'b0, 16'h0000);

      // reset in the third cycle of a 7-cycle stall
      idle(1);
      model_access(32'h0800_0000, SZ_WORD, 1'b0, 16'h0000);
      addr = 32'h0800_0000; size = SZ_WORD; write = 1'b0; waitcnt = 16'h0000; req = 1'b1;
      @(posedge clk); #1;
      check_eq("rst_stall.pause_on", {31'd0, pause}, 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; req = 1'b0;
      #1;
      check_eq("rst_stall.pause_drop", {31'd0, pause}, 32'd0);
      check_eq("rst_stall.seq", {31'd0, seq}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_prev_valid = 1'b0;
      access("post_rst", 32'h0800_0004, SZ_WORD, 1'b0, 16'h0000);

      r_wc = 16'($urandom);
      for (int i = 0; i < 200; i++) begin
         mode = $urandom_range(0, 9);
         if (mode <= 4) begin
            r_addr = last_end;
         end else if (mode == 5) begin
            r_addr = {4'h0, 4'($urandom_range(8, 13)), 7'($urandom), 17'h1FFFE};
         end else if (mode == 6) begin
            r_addr = 32'($urandom);
         end else begin
            r_addr = {4'h0, 4'($urandom_range(0, 15)), 24'($urandom)};
         end
         r_size  = 2'($urandom_range(0, 2));
         r_write = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 4) == 0) r_wc = 16'($urandom);
         if ($urandom_range(0, 6) == 0) idle(1);
         access("rand", r_addr, r_size, r_write, r_wc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
